ccff_bitstream_loader: RTL



---
 rtl/ccff_bitstream_loader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serialises parallel configuration words into the
// head of a configuration flip-flop chain, MSB first, exactly CHAIN_LEN bits.
// Words arrive over valid/ready and are buffered in a shift register plus a
// one-word skid slot. The loader also accumulates the parity of the chain tail.
module ccff_bitstream_loader #(
  parameter int WORD_WIDTH = 32,
  parameter int CHAIN_LEN  = 1024,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  ccff_head,
  output logic                  ccff_en,
  input  logic                  ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  tail_parity
);

  localparam int NWORDS = (CHAIN_LEN + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int WCNT_W = $clog2(NWORDS + 1);
  localparam int SH_W   = $clog2(WORD_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [SH_W-1:0]       shcnt_q, shcnt_d;
  logic [WORD_WIDTH-1:0] skid_q, skid_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  head_q, head_d;
  logic                  en_q, en_d;
  logic                  par_q, par_d;

  logic handshake;
  logic chain_full;
  logic words_left;
  logic from_skid;
  logic bit_avail;

  assign handshake  = word_valid & word_ready;
  assign chain_full = (cnt_q == CNT_W'(CHAIN_LEN));
  assign words_left = (wcnt_q < WCNT_W'(NWORDS));
  // Current word exhausted: the next bit comes straight from the skid slot.
  assign from_skid  = (shcnt_q == '0) && skid_vld_q;
  assign bit_avail  = (state_q == S_SHIFT) && !chain_full &&
                      ((shcnt_q != '0) || skid_vld_q);

  // State and datapath registers with synchronous reset
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      shcnt_q    <= '0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      wcnt_q     <= '0;
      cnt_q      <= '0;
      head_q     <= 1'b0;
      en_q       <= 1'b0;
      par_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      shcnt_q    <= shcnt_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      wcnt_q     <= wcnt_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      en_q       <= en_d;
      par_q      <= par_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (handshake) state_d = S_SHIFT;
      S_SHIFT: if (chain_full) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs, decoded from registered state only
  always_comb begin
    word_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_LOAD: begin
        word_ready = 1'b1;
        busy       = 1'b1;
      end
      S_SHIFT: begin
        busy       = 1'b1;
        word_ready = words_left && (!skid_vld_q || (bit_avail && from_skid));
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Serialiser datapath: buffer words, emit one bit per cycle, track parity
  always_comb begin
    shreg_d    = shreg_q;
    shcnt_d    = shcnt_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    wcnt_d     = wcnt_q;
    cnt_d      = cnt_q;
    head_d     = head_q;
    en_d       = 1'b0;
    par_d      = par_q ^ (en_q & ccff_tail);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d      = '0;
          par_d      = 1'b0;
          wcnt_d     = '0;
          shcnt_d    = '0;
          skid_vld_d = 1'b0;
        end
      end
      S_LOAD: begin
        // The first word's MSB is emitted on the accepting edge so the chain
        // starts one cycle after the handshake.
        if (handshake) begin
          head_d  = word_data[WORD_WIDTH-1];
          shreg_d = word_data << 1;
          shcnt_d = SH_W'(WORD_WIDTH - 1);
          en_d    = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          wcnt_d  = wcnt_q + WCNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (bit_avail) begin
          en_d  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (from_skid) begin
            head_d     = skid_q[WORD_WIDTH-1];
            shreg_d    = skid_q << 1;
            shcnt_d    = SH_W'(WORD_WIDTH - 1);
            skid_vld_d = 1'b0;
          end else begin
            head_d  = shreg_q[WORD_WIDTH-1];
            shreg_d = shreg_q << 1;
            shcnt_d = shcnt_q - SH_W'(1);
          end
        end
        // A word may land in the skid slot on the same cycle it empties.
        if (handshake) begin
          skid_d     = word_data;
          skid_vld_d = 1'b1;
          wcnt_d     = wcnt_q + WCNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign ccff_head   = head_q;
  assign ccff_en     = en_q;
  assign tail_parity = par_q;

endmodule
